morse_decoder: RTL and testbench



---
 rtl/morse_pkg.sv | 51 +++++
 rtl/morse_lut.sv | 38 +++
 rtl/morse_decoder.sv | 176 +++++++++++++++++
 tb/tb_morse_decoder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared types and constants for the Morse receiver:
//   - state_e  : decoder FSM states
//   - letter_e : 3-bit selector codes for letters A..H (matches transmitter)
//   - PAT_x / LEN_x : element pattern (first element at bit 0, dot=0, dash=1)
//                     and element count for each supported letter
// -----------------------------------------------------------------------------
package morse_pkg;

    localparam int unsigned PAT_W = 4;  // pattern register width (max elements)
    localparam int unsigned CNT_W = 3;  // element counter width (0..4)

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MARK,
        ST_SPACE,
        ST_ERR_WAIT
    } state_e;

    typedef enum logic [2:0] {
        LTR_A = 3'd0,
        LTR_B = 3'd1,
        LTR_C = 3'd2,
        LTR_D = 3'd3,
        LTR_E = 3'd4,
        LTR_F = 3'd5,
        LTR_G = 3'd6,
        LTR_H = 3'd7
    } letter_e;

    // Patterns are read right-to-left: bit 0 is the first element sent.
    localparam logic [PAT_W-1:0] PAT_A = 4'b0010;  // .-
    localparam logic [PAT_W-1:0] PAT_B = 4'b0001;  // -...
    localparam logic [PAT_W-1:0] PAT_C = 4'b0101;  // -.-.
    localparam logic [PAT_W-1:0] PAT_D = 4'b0001;  // -..
    localparam logic [PAT_W-1:0] PAT_E = 4'b0000;  // .
    localparam logic [PAT_W-1:0] PAT_F = 4'b0100;  // ..-.
    localparam logic [PAT_W-1:0] PAT_G = 4'b0011;  // --.
    localparam logic [PAT_W-1:0] PAT_H = 4'b0000;  // ....

    localparam logic [CNT_W-1:0] LEN_A = 3'd2;
    localparam logic [CNT_W-1:0] LEN_B = 3'd4;
    localparam logic [CNT_W-1:0] LEN_C = 3'd4;
    localparam logic [CNT_W-1:0] LEN_D = 3'd3;
    localparam logic [CNT_W-1:0] LEN_E = 3'd1;
    localparam logic [CNT_W-1:0] LEN_F = 3'd4;
    localparam logic [CNT_W-1:0] LEN_G = 3'd3;
    localparam logic [CNT_W-1:0] LEN_H = 3'd4;

endpackage : morse_pkg

// File: rtl/morse_lut.sv
// -----------------------------------------------------------------------------
// morse_lut
// Combinational letter lookup. Pattern alone is ambiguous (B/D and E/H share
// bit patterns), so the element count is part of the key.
//   pattern_i  [3:0] : collected elements, first at bit 0, dash=1
//   elem_cnt_i [2:0] : number of valid elements in pattern_i
//   letter_o   [2:0] : letter code A=000 .. H=111 (A when no hit)
//   hit_o            : 1 when {pattern_i, elem_cnt_i} is a known letter
// -----------------------------------------------------------------------------
module morse_lut
    import morse_pkg::*;
(
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [CNT_W-1:0] elem_cnt_i,
    output logic [2:0]       letter_o,
    output logic             hit_o
);

    always_comb begin
        letter_o = LTR_A;
        hit_o    = 1'b0;
        unique case ({pattern_i, elem_cnt_i})
            {PAT_A, LEN_A}: begin letter_o = LTR_A; hit_o = 1'b1; end
            {PAT_B, LEN_B}: begin letter_o = LTR_B; hit_o = 1'b1; end
            {PAT_C, LEN_C}: begin letter_o = LTR_C; hit_o = 1'b1; end
            {PAT_D, LEN_D}: begin letter_o = LTR_D; hit_o = 1'b1; end
            {PAT_E, LEN_E}: begin letter_o = LTR_E; hit_o = 1'b1; end
            {PAT_F, LEN_F}: begin letter_o = LTR_F; hit_o = 1'b1; end
            {PAT_G, LEN_G}: begin letter_o = LTR_G; hit_o = 1'b1; end
            {PAT_H, LEN_H}: begin letter_o = LTR_H; hit_o = 1'b1; end
            default: begin
                letter_o = LTR_A;
                hit_o    = 1'b0;
            end
        endcase
    end

endmodule : morse_lut

// File: rtl/morse_decoder.sv
// -----------------------------------------------------------------------------
// morse_decoder
// Serial Morse receiver for letters A..H. Samples serial_in once per tick,
// measures mark/space run lengths, collects dots and dashes and decodes the
// letter when a full letter gap of low samples has been seen.
//   clock        : system clock
//   reset        : synchronous, active-high; has priority over tick
//   tick         : one-clock enable per Morse time unit
//   serial_in    : Morse line, 1 = mark
//   letter       : last decoded letter code (A=000 .. H=111), held
//   letter_valid : one-clock pulse when letter is updated
//   error        : one-clock pulse on a malformed or unknown symbol
// -----------------------------------------------------------------------------
module morse_decoder #(
    parameter int unsigned DOT_UNITS  = 1,
    parameter int unsigned DASH_UNITS = 3,
    parameter int unsigned LETTER_GAP = 3,
    parameter int unsigned MAX_ELEMS  = 4,
    parameter int unsigned RUN_W      = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       serial_in,
    output logic [2:0] letter,
    output logic       letter_valid,
    output logic       error
);

    import morse_pkg::*;

    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [RUN_W-1:0] DOT_RUN  = RUN_W'(DOT_UNITS);
    localparam logic [RUN_W-1:0] DASH_RUN = RUN_W'(DASH_UNITS);
    localparam logic [RUN_W-1:0] GAP_RUN  = RUN_W'(LETTER_GAP);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_ELEMS);

    state_e             state_q, state_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [PAT_W-1:0]   pattern_q, pattern_d;
    logic [CNT_W-1:0]   elem_cnt_q, elem_cnt_d;
    logic [2:0]         letter_q, letter_d;
    logic               letter_valid_q, letter_valid_d;
    logic               error_q, error_d;

    logic [RUN_W-1:0]   run_inc;
    logic               is_dot, is_dash;
    logic               go_err;
    logic [2:0]         lut_letter;
    logic               lut_hit;

    // Decode sees the registered pattern: at the gap tick no element is
    // being appended, so pattern_q/elem_cnt_q are already complete.
    morse_lut u_lut (
        .pattern_i  (pattern_q),
        .elem_cnt_i (elem_cnt_q),
        .letter_o   (lut_letter),
        .hit_o      (lut_hit)
    );

    // Saturating increment: very long marks stay at all-ones and never
    // alias back to a dot or dash length.
    assign run_inc = (&run_q) ? run_q : run_q + RUN_ONE;
    assign is_dot  = (run_q == DOT_RUN);
    assign is_dash = (run_q == DASH_RUN);

    always_comb begin
        state_d        = state_q;
        run_d          = run_q;
        pattern_d      = pattern_q;
        elem_cnt_d     = elem_cnt_q;
        letter_d       = letter_q;
        letter_valid_d = 1'b0;
        error_d        = 1'b0;
        go_err         = 1'b0;

        if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (serial_in) begin
                        state_d = ST_MARK;
                        run_d   = RUN_ONE;
                    end
                end

                ST_MARK: begin
                    if (serial_in) begin
                        run_d = run_inc;
                    end else if (!(is_dot || is_dash) || (elem_cnt_q == CNT_MAX)) begin
                        go_err = 1'b1;
                    end else begin
                        pattern_d[elem_cnt_q[1:0]] = is_dash;
                        elem_cnt_d = elem_cnt_q + CNT_W'(1);
                        state_d    = ST_SPACE;
                        run_d      = RUN_ONE;
                    end
                end

                ST_SPACE: begin
                    if (!serial_in) begin
                        run_d = run_inc;
                        if (run_inc == GAP_RUN) begin
                            if (lut_hit) begin
                                letter_d       = lut_letter;
                                letter_valid_d = 1'b1;
                            end else begin
                                // Unknown symbol: the gap is already complete,
                                // so return to IDLE instead of ERR_WAIT.
                                error_d = 1'b1;
                            end
                            pattern_d  = '0;
                            elem_cnt_d = '0;
                            run_d      = '0;
                            state_d    = ST_IDLE;
                        end
                    end else if (run_q == RUN_ONE) begin
                        state_d = ST_MARK;
                        run_d   = RUN_ONE;
                    end else begin
                        go_err = 1'b1;
                    end
                end

                ST_ERR_WAIT: begin
                    // Resynchronise: only a full letter gap of lows re-arms.
                    if (serial_in) begin
                        run_d = '0;
                    end else if (run_inc == GAP_RUN) begin
                        run_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        run_d = run_inc;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    run_d   = '0;
                end
            endcase

            if (go_err) begin
                error_d    = 1'b1;
                pattern_d  = '0;
                elem_cnt_d = '0;
                run_d      = '0;
                state_d    = ST_ERR_WAIT;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            run_q          <= '0;
            pattern_q      <= '0;
            elem_cnt_q     <= '0;
            letter_q       <= '0;
            letter_valid_q <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            run_q          <= run_d;
            pattern_q      <= pattern_d;
            elem_cnt_q     <= elem_cnt_d;
            letter_q       <= letter_d;
            letter_valid_q <= letter_valid_d;
            error_q        <= error_d;
        end
    end

    assign letter       = letter_q;
    assign letter_valid = letter_valid_q;
    assign error        = error_q;

endmodule : morse_decoder

// File: tb/tb_morse_decoder.sv
// -----------------------------------------------------------------------------
// tb_morse_decoder
// Scoreboard bench: a string-based reference model predicts every
// letter_valid / error pulse (kind, letter, tick number); a monitor on the
// falling edge pops and compares each pulse the DUT presents.
// -----------------------------------------------------------------------------
module tb_morse_decoder;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       serial_in = 1'b0;
    logic [2:0] letter;
    logic       letter_valid;
    logic       error;

    morse_decoder #(
        .DOT_UNITS  (1),
        .DASH_UNITS (3),
        .LETTER_GAP (3),
        .MAX_ELEMS  (4),
        .RUN_W      (3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .tick         (tick),
        .serial_in    (serial_in),
        .letter       (letter),
        .letter_valid (letter_valid),
        .error        (error)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          is_err;
        logic [2:0]  ltr;
        int unsigned at_tick;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp    = 0;
    int unsigned n_bad    = 0;
    int unsigned tick_cnt = 0;
    bit          gate_rand = 1'b0;

    // Reference model: letters as dot/dash strings, index = letter code.
    string       code_tbl[8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};
    string       m_elems  = "";
    int          m_run    = 0;
    bit          m_active = 1'b0;
    bit          m_mark   = 1'b0;
    bit          m_recover = 1'b0;
    logic [2:0]  m_letter = 3'd0;

    task automatic check(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        m_elems   = "";
        m_run     = 0;
        m_active  = 1'b0;
        m_mark    = 1'b0;
        m_recover = 1'b0;
        m_letter  = 3'd0;
    endfunction

    function automatic void model_err(input int unsigned at);
        sb.push_back('{1'b1, m_letter, at});
        m_elems   = "";
        m_run     = 0;
        m_active  = 1'b0;
        m_mark    = 1'b0;
        m_recover = 1'b1;
    endfunction

    function automatic void model_decode(input int unsigned at);
        int idx = -1;
        foreach (code_tbl[i]) if (code_tbl[i] == m_elems) idx = i;
        if (idx >= 0) begin
            m_letter = 3'(idx);
            sb.push_back('{1'b0, m_letter, at});
        end else begin
            sb.push_back('{1'b1, m_letter, at});
        end
        m_elems  = "";
        m_run    = 0;
        m_active = 1'b0;
        m_mark   = 1'b0;
    endfunction

    // One Morse time unit: a mark of 1 unit is a dot, 3 units a dash; a
    // 1-unit low separates elements, 3 low units end the letter.
    function automatic void model_step(input bit s, input int unsigned at);
        string e;
        if (m_recover) begin
            if (s) m_run = 0;
            else begin
                m_run++;
                if (m_run == 3) begin
                    m_recover = 1'b0;
                    m_run     = 0;
                end
            end
        end else if (!m_active) begin
            if (s) begin
                m_active = 1'b1;
                m_mark   = 1'b1;
                m_run    = 1;
            end
        end else if (m_mark) begin
            if (s) m_run++;
            else if ((m_run == 1 || m_run == 3) && m_elems.len() < 4) begin
                if (m_run == 1) e = ".";
                else            e = "-";
                m_elems = {m_elems, e};
                m_mark  = 1'b0;
                m_run   = 1;
            end else begin
                model_err(at);
            end
        end else begin
            if (!s) begin
                m_run++;
                if (m_run == 3) model_decode(at);
            end else if (m_run == 1) begin
                m_mark = 1'b1;
                m_run  = 1;
            end else begin
                model_err(at);
            end
        end
    endfunction

    task automatic hold_off(input int n);
        for (int i = 0; i < n; i++) begin
            tick      = 1'b0;
            serial_in = 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
        end
        tick = 1'b0;
    endtask

    task automatic send(input bit s);
        if (gate_rand && $urandom_range(0, 3) == 0) hold_off(int'($urandom_range(1, 3)));
        tick      = 1'b1;
        serial_in = s;
        model_step(s, tick_cnt + 1);
        @(posedge clock);
        tick_cnt++;
        #1;
        tick = 1'b0;
    endtask

    task automatic send_seq(input string bits);
        for (int i = 0; i < bits.len(); i++) send(bits[i] == "1");
    endtask

    function automatic string letter_bits(input int idx);
        string s = "";
        string c = code_tbl[idx];
        for (int k = 0; k < c.len(); k++) begin
            if (k > 0) s = {s, "0"};
            if (c[k] == ".") s = {s, "1"};
            else             s = {s, "111"};
        end
        s = {s, "000"};
        return s;
    endfunction

    task automatic do_reset();
        check("pending_at_reset", sb.size(), 0);
        sb.delete();
        reset = 1'b1;
        tick  = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        check("reset_letter", int'(letter), 0);
        check("reset_valid", int'(letter_valid), 0);
        check("reset_error", int'(error), 0);
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (letter_valid && error) check("valid_error_exclusive", 1, 0);
            if (letter_valid || error) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pulse: got valid=%0b error=%0b letter=%0d, expected none (t=%0t)",
                             letter_valid, error, letter, $time);
                end else begin
                    e = sb.pop_front();
                    check("pulse_is_error", int'(error), int'(e.is_err));
                    check("pulse_letter", int'(letter), int'(e.ltr));
                    check("pulse_tick", int'(tick_cnt), int'(e.at_tick));
                end
            end
        end
    end

    initial begin
        string s;
        int    n;
        repeat (2) @(posedge clock);
        #1;
        do_reset();

        // A, then H and F back to back
        send_seq("10111000");
        send_seq("1010101000");
        send_seq("101011101000");

        // Bad mark, recovery gap, then E
        send_seq("110");
        send_seq("000");
        send_seq("1000");

        // Five dots (overflow), recovery, then undefined ---
        send_seq("1010101010");
        send_seq("000");
        send_seq("111011101110000");

        // D with a long tick-gated stretch mid-letter
        send_seq("1110");
        hold_off(20);
        send_seq("101000");

        // Reset mid-letter, then E must decode cleanly
        send_seq("101");
        do_reset();
        send_seq("1000");

        // Randomized letters, junk and tick gating
        gate_rand = 1'b1;
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 9) < 7) begin
                send_seq(letter_bits(int'($urandom_range(0, 7))));
            end else begin
                s = "";
                n = int'($urandom_range(1, 3));
                for (int p = 0; p < n; p++) begin
                    for (int k = 0; k < int'($urandom_range(1, 6)); k++) s = {s, "1"};
                    for (int k = 0; k < int'($urandom_range(1, 2)); k++) s = {s, "0"};
                end
                s = {s, "000"};
                send_seq(s);
            end
        end
        gate_rand = 1'b0;

        hold_off(5);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_morse_decoder
